// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into imem words and holds the core in reset until done.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic             reload,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [CNT_W-1:0] words_loaded
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_ERR   = 3'd5,
    S_CHECK = 3'd6
`else
    S_ERR   = 3'd5
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] len, len_n;
  logic [1:0]       bidx, bidx_n;
  logic [31:0]      wbuf, wbuf_n;
  logic             we_n, core_reset_n, done_n, err_n;
  logic [31:0]      addr_n, wdata_n;
  logic [CNT_W-1:0] wl_n, len_rx;
  logic             accept, finish_frame;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum, csum_n;
`endif

  // Ready is a pure state decode, forced low while reset is held.
  always_comb begin
    byte_ready = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA: byte_ready = reset;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                byte_ready = reset;
`endif
      default:                byte_ready = 1'b0;
    endcase
  end

  assign accept = byte_valid && byte_ready;
  assign len_rx = CNT_W'({byte_data, len[7:0]});

  // Next-state and next-output computation; every register below takes its *_n value.
  always_comb begin
    state_n      = state;
    len_n        = len;
    bidx_n       = bidx;
    wbuf_n       = wbuf;
    we_n         = 1'b0;
    addr_n       = imem_addr;
    wdata_n      = imem_wdata;
    core_reset_n = core_reset;
    done_n       = load_done;
    err_n        = load_error;
    wl_n         = words_loaded;
    finish_frame = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_n       = csum;
`endif

    case (state)
      S_LEN0: begin
        if (accept) begin
          len_n   = CNT_W'(byte_data);
          state_n = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_n = len_rx;
          if (len_rx > DEPTH_C) begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end else if (len_rx == '0) begin
            finish_frame = 1'b1;
          end else begin
            state_n = S_DATA;
            bidx_n  = 2'd0;
            wl_n    = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wbuf_n[{bidx, 3'b000} +: 8] = byte_data;
          bidx_n = bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_n = csum ^ byte_data;
`endif
          if (bidx == 2'd3) begin
            state_n = S_WRITE;
            we_n    = 1'b1;
            addr_n  = 32'({words_loaded, 2'b00});
            wdata_n = {byte_data, wbuf[23:0]};
          end
        end
      end
      S_WRITE: begin
        wl_n = words_loaded + CNT_W'(1);
        if ((words_loaded + CNT_W'(1)) == len) begin
          finish_frame = 1'b1;
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (byte_data == csum) begin
            state_n      = S_DONE;
            done_n       = 1'b1;
            core_reset_n = 1'b0;
          end else begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (reload) begin
          state_n      = S_LEN0;
          len_n        = '0;
          bidx_n       = 2'd0;
          wl_n         = '0;
          done_n       = 1'b0;
          err_n        = 1'b0;
          core_reset_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_n       = 8'd0;
`endif
        end
      end
      default: state_n = S_LEN0;
    endcase

    // End of data (or an empty frame): either await the checksum or release the core.
    if (finish_frame) begin
`ifdef LOADER_CHECKSUM_EN
      state_n = S_CHECK;
`else
      state_n      = S_DONE;
      done_n       = 1'b1;
      core_reset_n = 1'b0;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_LEN0;
      len          <= '0;
      bidx         <= 2'd0;
      wbuf         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state        <= state_n;
      len          <= len_n;
      bidx         <= bidx_n;
      wbuf         <= wbuf_n;
      imem_we      <= we_n;
      imem_addr    <= addr_n;
      imem_wdata   <= wdata_n;
      core_reset   <= core_reset_n;
      load_done    <= done_n;
      load_error   <= err_n;
      words_loaded <= wl_n;
`ifdef LOADER_CHECKSUM_EN
      csum         <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a frame-level model predicts writes, final status and release latency.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, byte_valid, reload;
  logic [7:0]       byte_data;
  logic             byte_ready, imem_we, core_reset, load_done, load_error;
  logic [31:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] fw [DEPTH];
  logic [31:0] snap [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: records every imem write and checks the WRITE-cycle handshake rules.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      chk("ready_in_write", 32'(byte_ready), 32'd0);
      chk("core_reset_in_write", 32'(core_reset), 32'd1);
      if (imem_addr < 32'(DEPTH * 4)) mem[imem_addr[7:2]] = imem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    bit acc = 1'b0;
    int gap = (gap_max > 0) ? int'($urandom_range(1, gap_max)) : 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
    end
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      acc        = byte_ready;
      @(posedge clk);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reload();
    @(negedge clk);
    byte_valid = 1'b0;
    reload     = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_done", 32'(load_done), 32'd0);
    chk("reload_error", 32'(load_error), 32'd0);
    chk("reload_words", 32'(words_loaded), 32'd0);
    chk("reload_ready", 32'(byte_ready), 32'd1);
  endtask

  // Sends a frame of n words from fw[] and checks it against the frame-level expectation.
  task automatic run_frame(input int n, input bit bad_cks, input int gap_max);
    logic [7:0] cks = 8'd0;
    logic [31:0] w;
    bit cks_on, ok;
    int exp_writes, lat;
`ifdef LOADER_CHECKSUM_EN
    cks_on = 1'b1;
`else
    cks_on = 1'b0;
`endif
    ok         = (n <= DEPTH) && !(cks_on && bad_cks);
    exp_writes = (n <= DEPTH) ? n : 0;
    lat        = (!cks_on && n > 0 && n <= DEPTH) ? 2 : 1;
    wr_addr_q.delete();
    wr_data_q.delete();

    send_byte(8'(n), gap_max);
    send_byte(8'(n >> 8), gap_max);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = fw[i];
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8], gap_max);
          cks = cks ^ w[8*k +: 8];
        end
      end
      if (cks_on) send_byte(bad_cks ? ~cks : cks, gap_max);
    end

    for (int l = 1; l <= lat; l++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (l == 1 && lat == 2) begin
        chk("write_latency", 32'(imem_we), 32'd1);
        chk("not_released_early", 32'(core_reset), 32'd1);
      end
    end
    chk("load_done", 32'(load_done), 32'(ok));
    chk("load_error", 32'(load_error), 32'(!ok));
    chk("core_reset", 32'(core_reset), 32'(!ok));
    chk("words_loaded", 32'(words_loaded), 32'(exp_writes));
    chk("write_count", 32'(wr_addr_q.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
      chk("write_addr", wr_addr_q[i], 32'(i * 4));
      chk("write_data", wr_data_q[i], fw[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b0; byte_valid = 1'b0; byte_data = 8'd0; reload = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(byte_ready), 32'd1);

    // Two-instruction program, back to back.
    fw[0] = 32'h0050_0513;
    fw[1] = 32'h00A0_0593;
    run_frame(2, 1'b0, 0);
    chk("mem0", mem[0], 32'h0050_0513);
    chk("mem1", mem[1], 32'h00A0_0593);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    run_frame(2, 1'b1, 0);
`endif

    do_reload();
    run_frame(65, 1'b0, 0);

    // Same random 4-word program back to back, then with idle gaps.
    do_reload();
    for (int i = 0; i < 4; i++) fw[i] = $urandom;
    run_frame(4, 1'b0, 0);
    for (int i = 0; i < 4; i++) snap[i] = mem[i];
    do_reload();
    run_frame(4, 1'b0, 3);
    for (int i = 0; i < 4; i++) chk("imem_same", mem[i], snap[i]);

    // Reset asserted after 6 data bytes of a 3-word frame.
    do_reload();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 3; i++) fw[i] = $urandom;
    send_byte(8'd3, 0);
    send_byte(8'd0, 0);
    for (int k = 0; k < 6; k++) send_byte(8'(fw[k / 4] >> (8 * (k % 4))), 0);
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_writes", 32'(wr_addr_q.size()), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    fw[0] = $urandom;
    run_frame(1, 1'b0, 0);
    chk("midrst_mem0", mem[0], fw[0]);

    // Reload from DONE overwrites address 0.
    do_reload();
    fw[0] = ~fw[0];
    run_frame(1, 1'b0, 1);
    chk("reload_mem0", mem[0], fw[0]);

    // Boundaries: empty frame and a full-depth frame.
    do_reload();
    run_frame(0, 1'b0, 0);
    do_reload();
    for (int i = 0; i < DEPTH; i++) fw[i] = $urandom;
    run_frame(DEPTH, 1'b0, 0);

    // Random frames, lengths, gaps and checksum corruption.
    for (int it = 0; it < 12; it++) begin
      do_reload();
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 65535)) : int'($urandom_range(0, 6));
      for (int i = 0; i < DEPTH; i++) fw[i] = $urandom;
      run_frame(n, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory. It also gates the single-cycle core's reset.
- Receives a byte stream over a valid/ready link (UART receiver or bench driver) and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into imem from address 0, then releases the core from reset.
- Replaces the file-based imem preload so the same design runs in simulation and on the DigitalJS/FPGA flow.

Parameters:
- DEPTH, 64, imem capacity in 32-bit words; a frame declaring more words is rejected.
- CNT_W, 16, width of the frame word-count field and the internal word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = asserted).
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  single-cycle pulse; restarts loading from DONE or ERR.
- imem_we  output  1  imem write strobe.
- imem_addr  output  32  imem byte address, word aligned.
- imem_wdata  output  32  assembled instruction word.
- core_reset  output  1  active-high reset driven to the core (top/riscvsingle).
- load_done  output  1  program loaded successfully.
- load_error  output  1  frame rejected.
- words_loaded  output  CNT_W  count of words written so far.

Behaviour:
- Reset values (reset=0, applied asynchronously):
  - state=LEN0; imem_we=0; imem_addr=0; imem_wdata=0.
  - core_reset=1; load_done=0; load_error=0; words_loaded=0.
  - byte_ready=0 while reset is low.
- Handshake: a byte is accepted only on a rising edge with byte_valid&&byte_ready.
  - byte_data is sampled only on acceptance; byte_valid without ready is held off, never dropped.
- byte_ready is decoded from state: 1 in LEN0, LEN1, DATA, CHECK; 0 in WRITE, DONE, ERR.
- Frame format: LEN_LO, LEN_HI (N, little-endian), N*4 data bytes, then a CHECK byte when the optional feature is enabled.
- State transitions:
  - LEN0: accept -> latch N[7:0], go to LEN1.
  - LEN1: accept -> latch N[15:8].
    - If N>DEPTH -> ERR.
    - If N==0 -> CHECK, or DONE when the feature is disabled.
    - Otherwise -> DATA with byte index 0 and word index 0.
  - DATA: each accepted byte k (0..3) goes to wdata[8k+7:8k]. The first byte lands in [7:0]. After byte 3 -> WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr={word_idx,2'b00}, imem_wdata=assembled word.
    - Next edge: word_idx and words_loaded increment.
    - If word_idx+1==N -> CHECK (or DONE); else -> DATA.
  - CHECK: accept -> compare with the running XOR of all data bytes. Equal -> DONE; different -> ERR.
  - DONE: load_done=1, core_reset=0. Stays here until reload or reset.
  - ERR: load_error=1, core_reset=1. Stays here until reload or reset.
- reload:
  - In DONE/ERR: next edge goes to LEN0 and clears counters, checksum, load_done and load_error. core_reset=1 from that edge.
  - In any other state reload is ignored.
- imem_we is asserted only in WRITE. It is never asserted for words at index >= N or >= DEPTH.
- Latency: final data byte accepted -> imem_we high the next cycle. Core is released 1 cycle after the last write (feature off) or 1 cycle after the checksum byte is accepted (feature on).
- Reset mid-frame: partial word is discarded. Words already written stay in imem; loading restarts at LEN0.
- All outputs are registered except byte_ready, which is state decode gated by reset.

Optional Feature:
- LOADER_CHECKSUM_EN
- Defined: CHECK state exists. A trailing XOR checksum byte is required; a mismatch gives ERR and the core stays in reset.
- Undefined: no CHECK state and no checksum logic. WRITE of the last word (or LEN1 with N==0) goes directly to DONE; ERR is reachable only through N>DEPTH.

Test Plan:
- Feature on, frame 02 00 | 13 05 50 00 | 93 05 A0 00 | checksum:
  - Writes 0x00500513 at addr 0x0 and 0x00A00593 at addr 0x4.
  - load_done=1, core_reset falls 1 cycle after the checksum byte, words_loaded=2.
- Same frame with the checksum byte flipped -> load_error=1, core_reset stays 1, load_done=0.
- LEN=0x0041 (65 > DEPTH) -> ERR right after LEN_HI is accepted; no imem_we pulse.
- byte_valid toggled randomly with 1-3 idle cycles between bytes, 4-word frame:
  - Identical imem contents to the back-to-back case.
  - byte_ready=0 in the WRITE cycle; no byte lost or duplicated.
- Assert reset=0 after 6 data bytes of a 3-word frame:
  - Immediately: core_reset=1, byte_ready=0.
  - After release: a full 1-word reload writes addr 0 and reaches DONE.
- From DONE, pulse reload and send a new 1-word frame:
  - core_reset=1 during loading, addr 0 is overwritten, DONE is re-entered.
  - With the feature undefined, the first case reaches DONE with no checksum byte.
